// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: mid-bit sampling, parity/stop checking, level/ack handshake.
// Define RX_SERIAL_PARITY_CHECK_EN to enable the parity checker (otherwise erro_paridade is tied to 0).
module rx_serial_7e1 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       apaga,
    output logic [6:0] dados_ascii,
    output logic       tem_dado,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic [3:0] db_estado
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        FIM      = 4'd5,
        ESPERA   = 4'd6
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             rx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       shift_q, shift_d;
    logic             stop_q, stop_d;
    logic             load;
    logic [6:0]       dados_q;
    logic             tem_q, pronto_q, erro_stop_q;
`ifdef RX_SERIAL_PARITY_CHECK_EN
    logic             par_q, par_d;
    logic             erro_par_q;
`endif

    // Idle-high line: synchronizer resets to 1 so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], dado_serial};
    end
    assign rx = sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INICIAL;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop_q  <= 1'b1;
`ifdef RX_SERIAL_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
`ifdef RX_SERIAL_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;
`ifdef RX_SERIAL_PARITY_CHECK_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        case (state_q)
            INICIAL: begin
                bit_d = '0;
                if (!rx) state_d = START;
            end
            START: begin
                // A line back high at start-bit centre was a glitch.
                if (cnt_q == HALF_LAST) state_d = rx ? INICIAL : DADOS;
            end
            DADOS: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rx, shift_q[6:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = '0;
                    if (bit_q == 3'd6) state_d = PARIDADE;
                end
            end
            PARIDADE: begin
                if (cnt_q == BIT_LAST) begin
`ifdef RX_SERIAL_PARITY_CHECK_EN
                    par_d = rx;
`endif
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    stop_d  = rx;
                    state_d = FIM;
                end
            end
            FIM: begin
                load    = 1'b1;
                state_d = stop_q ? INICIAL : ESPERA;
            end
            ESPERA: begin
                if (rx) state_d = INICIAL;
            end
            default: state_d = INICIAL;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs update only from FIM; a coincident acknowledge loses to new data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dados_q     <= '0;
            tem_q       <= 1'b0;
            pronto_q    <= 1'b0;
            erro_stop_q <= 1'b0;
`ifdef RX_SERIAL_PARITY_CHECK_EN
            erro_par_q  <= 1'b0;
`endif
        end else begin
            pronto_q <= load;
            if (load) begin
                dados_q     <= shift_q;
                erro_stop_q <= ~stop_q;
`ifdef RX_SERIAL_PARITY_CHECK_EN
                erro_par_q  <= (^shift_q) ^ par_q;
`endif
            end
            if (load)       tem_q <= 1'b1;
            else if (apaga) tem_q <= 1'b0;
        end
    end

    assign dados_ascii = dados_q;
    assign tem_dado    = tem_q;
    assign pronto      = pronto_q;
    assign erro_stop   = erro_stop_q;
    assign db_estado   = state_q;
`ifdef RX_SERIAL_PARITY_CHECK_EN
    assign erro_paridade = erro_par_q;
`else
    assign erro_paridade = 1'b0;
`endif

endmodule
